// File: rtl/mux_pkg.sv
// Shared types and constants for the 4:1 channel mux control family.
package mux_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] sel);
    return NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after 'last', wrapping to 'last' itself.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    pick = last;
    any  = 1'b0;
    idx  = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_channel_scanner.sv
// Round-robin channel scanner: drives mux selects, waits a settle time, requests a sample, waits for ack.
module mux_channel_scanner
  import mux_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ack,
  output logic               s1,
  output logic               s0,
  output logic               sel_valid,
  output logic [NCH-1:0]     grant,
  output logic               sample_req,
  output logic               busy
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               sel_valid_d, sample_req_d, busy_d;
  logic [NCH-1:0]     grant_d;
  logic [SEL_W-1:0]   pick;
  logic               any;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  assign s1 = sel_q[1];
  assign s0 = sel_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= SEL_W'(NCH - 1);
      cnt_q      <= '0;
      sel_valid  <= 1'b0;
      grant      <= '0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      sel_valid  <= sel_valid_d;
      grant      <= grant_d;
      sample_req <= sample_req_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    sel_valid_d  = sel_valid;
    grant_d      = grant;
    sample_req_d = sample_req;
    busy_d       = busy;

    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = HOLD;
          sel_d       = pick;
          grant_d     = onehot(pick);
          sel_valid_d = 1'b1;
          cnt_d       = dwell;
        end else begin
          sel_valid_d = 1'b0;
          grant_d     = '0;
        end
      end
      // Abort takes priority over the settle count; exit test precedes decrement.
      HOLD: begin
        if (!req[sel_q]) begin
          state_d     = IDLE;
          sel_valid_d = 1'b0;
          grant_d     = '0;
        end else if (cnt_q == '0) begin
          state_d      = SAMPLE;
          sample_req_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      SAMPLE: begin
        if (ack) begin
          state_d      = IDLE;
          last_d       = sel_q;
          sample_req_d = 1'b0;
          sel_valid_d  = 1'b0;
          grant_d      = '0;
        end
      end
      default: begin
        state_d      = IDLE;
        sel_valid_d  = 1'b0;
        grant_d      = '0;
        sample_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench for mux_channel_scanner: driver pushes expected grants/latencies, monitor pops and compares.
module tb_mux_channel_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] dwell = 4'd0;
  logic       ack = 1'b0;
  logic       s1, s0, sel_valid, sample_req, busy;
  logic [3:0] grant;

  int checks = 0;
  int failures = 0;
  int exp_grant_q[$];
  int exp_lat_q[$];
  int model_last = 3;

  bit         mon_pv = 1'b0;
  bit         mon_ps = 1'b0;
  int         mon_psel = 0;
  logic [3:0] mon_pg = 4'd0;
  int         mon_cyc = 0;
  int         mon_t0 = 0;
  int         mon_e = 0;

  mux_channel_scanner #(.DWELL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .dwell      (dwell),
    .ack        (ack),
    .s1         (s1),
    .s0         (s0),
    .sel_valid  (sel_valid),
    .grant      (grant),
    .sample_req (sample_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference arbitration: first requesting channel after the last served one, wrapping.
  function automatic int ref_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      int ch;
      ch = (last + i) % 4;
      if (r[ch]) return ch;
    end
    return -1;
  endfunction

  // One request/grant transaction; called at a negedge with the DUT idle.
  task automatic txn(input logic [3:0] r, input logic [3:0] d, input bit abort_it,
                     input int k, input int stall);
    int ch;
    int n;
    req   = r;
    dwell = d;
    ack   = 1'b0;
    ch    = ref_pick(r, model_last);
    exp_grant_q.push_back(ch);
    if (!abort_it) exp_lat_q.push_back(int'(d) + 1);
    n = 0;
    while (!sel_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!sel_valid) begin
      check(1'b0, "sel_valid_timeout", 0, 1);
      return;
    end
    if (abort_it) begin
      repeat (k) @(negedge clk);
      req = 4'd0;
      @(negedge clk);
      check(!sel_valid && !sample_req && grant == 4'd0, "abort_drop",
            int'({sel_valid, sample_req}), 0);
      return;
    end
    n = 0;
    while (!sample_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!sample_req) begin
      check(1'b0, "sample_req_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      req = 4'($urandom);
      @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    req = 4'd0;
    model_last = ch;
    check(!sel_valid && !sample_req && grant == 4'd0, "ack_release",
          int'({sel_valid, sample_req}), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_cyc++;
        if (rst) begin
          mon_pv = 1'b0;
          mon_ps = 1'b0;
        end else begin
          check(($countones(grant) <= 1) && ((grant != 4'd0) == sel_valid), "inv_onehot",
                int'(grant), int'(sel_valid));
          if (sel_valid)
            check(grant == (4'b0001 << {s1, s0}), "inv_decode", int'(grant), int'({s1, s0}));
          if (sel_valid && mon_pv)
            check(grant == mon_pg && int'({s1, s0}) == mon_psel, "sel_stable",
                  int'(grant), int'(mon_pg));
          if (sel_valid && !mon_pv) begin
            if (exp_grant_q.size() == 0) begin
              check(1'b0, "unexpected_grant", int'(grant), 0);
            end else begin
              mon_e = exp_grant_q.pop_front();
              check(grant == (4'b0001 << mon_e) && int'({s1, s0}) == mon_e, "grant",
                    int'(grant), 1 << mon_e);
            end
            mon_t0 = mon_cyc;
          end
          if (sample_req && !mon_ps) begin
            if (exp_lat_q.size() == 0) begin
              check(1'b0, "unexpected_sample_req", 1, 0);
            end else begin
              mon_e = exp_lat_q.pop_front();
              check(mon_cyc - mon_t0 == mon_e, "sample_latency", mon_cyc - mon_t0, mon_e);
            end
          end
          if (sample_req)
            check(sel_valid && busy, "sample_hold", int'({sel_valid, busy}), 3);
          mon_pv   = sel_valid;
          mon_ps   = sample_req;
          mon_pg   = grant;
          mon_psel = int'({s1, s0});
        end
      end
    join_none

    #1 rst = 1'b1;
    #2;
    check({s1, s0, sel_valid, sample_req, busy} == 5'd0 && grant == 4'd0, "reset_values",
          int'({s1, s0, sel_valid, sample_req, busy}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    txn(4'b0001, 4'd2, 1'b0, 0, 0);
    repeat (5) txn(4'b1111, 4'd0, 1'b0, 0, 0);
    txn(4'b0010, 4'd0, 1'b0, 0, 0);
    repeat (3) txn(4'b1010, 4'd0, 1'b0, 0, 0);
    txn(4'b0100, 4'd5, 1'b1, 2, 0);
    txn(4'b0100, 4'd1, 1'b0, 0, 0);
    txn(4'b1111, 4'd1, 1'b0, 0, 10);

    for (int t = 0; t < 60; t++) begin
      logic [3:0] r;
      logic [3:0] d;
      bit         ab;
      r  = 4'($urandom_range(1, 15));
      d  = 4'($urandom_range(0, 6));
      ab = ($urandom_range(0, 4) == 0);
      txn(r, d, ab, $urandom_range(0, int'(d)), $urandom_range(0, 4));
    end

    // Park the pointer away from its reset value, then reset while sampling.
    txn(4'b0100, 4'd0, 1'b0, 0, 0);
    req   = 4'b1111;
    dwell = 4'd1;
    exp_grant_q.push_back(ref_pick(req, model_last));
    exp_lat_q.push_back(2);
    for (int n = 0; n < 20 && !sample_req; n++) @(negedge clk);
    check(sample_req == 1'b1, "reach_sample", int'(sample_req), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({s1, s0, sel_valid, sample_req, busy} == 5'd0 && grant == 4'd0, "async_reset",
          int'({s1, s0, sel_valid, sample_req, busy}), 0);
    model_last = 3;
    exp_grant_q.delete();
    exp_lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    txn(4'b1111, 4'd0, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    check(exp_grant_q.size() == 0 && exp_lat_q.size() == 0, "queues_drained",
          exp_grant_q.size() + exp_lat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
- Upstream control stage for the 4:1 decoder/tristate channel mux.
- Arbitrates four channel requests round-robin and drives the mux selects `s1`/`s0`.
- Holds each selection for a programmable settle (dwell) time, then raises a sample request and waits for the downstream capture stage to acknowledge.
- Guarantees that exactly one mux tristate is enabled while `sel_valid` is high, and that selects never change mid-sample.

Parameters:
- DWELL_W, 4, width of the dwell (settle) counter and of the `dwell` input.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel sample request; bit k requests mux input k.
- dwell  input  DWELL_W  settle cycles after select change; sampled on grant.
- ack  input  1  downstream has captured mux output; valid only while sample_req=1.
- s1  output  1  mux select MSB (to decoder a input).
- s0  output  1  mux select LSB (to decoder b input).
- sel_valid  output  1  selects are stable and a channel is granted.
- grant  output  4  one-hot granted channel, equals decode of {s1,s0} when sel_valid=1, else 0.
- sample_req  output  1  mux output has settled; downstream should capture.
- busy  output  1  FSM not in IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, rst=1):
  - state=IDLE; s1=0, s0=0, sel_valid=0, grant=0, sample_req=0, busy=0.
  - last pointer=3, so the first grant goes to ch0 when req[0] is set.
- FSM states: IDLE, HOLD, SAMPLE.
- IDLE:
  - If req!=0, pick the first set bit searching last+1, last+2, last+3, last (mod 4).
  - Next cycle: {s1,s0}=pick, grant=onehot(pick), sel_valid=1, cnt=dwell, state=HOLD.
  - If req==0, stay in IDLE; outputs unchanged except sel_valid=0 and grant=0 (selects retain their last value).
- HOLD:
  - If req[cur]=0: abort. Go to IDLE; sel_valid=0, grant=0; last pointer unchanged.
  - Else if cnt==0: state=SAMPLE, sample_req=1.
  - Else: cnt=cnt-1.
  - HOLD therefore lasts dwell+1 cycles; dwell=0 gives 1 cycle.
- SAMPLE:
  - sample_req held high and selects frozen until ack=1.
  - req changes are ignored in this state.
  - On ack: last=cur, sample_req=0, sel_valid=0, grant=0, state=IDLE.
- Latency: req seen in IDLE at edge N gives sel_valid at N+1 and sample_req at N+2+dwell. Minimum per-channel turnaround is dwell+3 cycles including the return through IDLE.
- ack while not in SAMPLE: ignored.
- Simultaneous ack and rst: rst wins.
- Reset mid-operation: immediate return to reset values; no partial sample is signalled.
- Counter: unsigned DWELL_W bits, decrement only, never wraps (the exit test precedes the decrement).
- Invariant: grant is one-hot or zero, and grant!=0 iff sel_valid=1.

Decomposition:
- Shared package/header mux_pkg:
  - State encodings: IDLE=2'd0, HOLD=2'd1, SAMPLE=2'd2.
  - NCH=4 and SEL_W=2.
- One sub-module, rr_pick4: combinational round-robin picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: pick[1:0], any.
  - Reused by later arbiters in the mux family.

Test Plan:
- Reset then req=4'b0001, dwell=2:
  - sel_valid rises 1 cycle after req, with s1s0=00 and grant=0001.
  - sample_req rises 4 cycles after req.
  - ack gives return to IDLE and sel_valid=0 next cycle.
- Round-robin fairness, req=4'b1111 held, dwell=0, ack pulsed on each sample_req: grant order 0001, 0010, 0100, 1000, 0001.
- Skip idle channels, req=4'b1010, last=1: next grant ch3 (1000), then ch1 (0010); ch0 and ch2 are never granted.
- Abort in HOLD, req=0100, dwell=5, drop req[2] after 2 cycles:
  - sel_valid=0 next cycle, sample_req never asserted.
  - Re-raise req=0100 and ch2 is granted again (last pointer unchanged).
- Stall in SAMPLE: withhold ack for 10 cycles while toggling req. s1s0, grant and sample_req stay constant; the first ack releases.
- Async reset in SAMPLE: assert rst between clock edges. All outputs drop to reset values immediately, and the next grant with req=1111 is ch0.
